uart_mmio_slave: RTL and testbench
==================================

Name: uart_mmio_slave

Overview:
- Memory-mapped UART peripheral: the slave behind the UART window 0x1001_0020–0x1001_003F of the core's memory-map master.
- Consumes the master's word-offset address, write data, write select and read select.
- Returns read data on the UART read-data return path (HRData2).
- Implements 8N1 transmit and receive with a fixed baud divider, exposed to the core as four 32-bit registers.

Parameters:
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width; only bits [2:0] (word offset) are decoded.
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate; localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be ≥ 4).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- map_Address  in  ADDR_WIDTH  word offset inside UART window (already byte-offset-subtracted and shifted right by 2).
- map_Data  in  DATA_WIDTH  write data.
- WSel  in  1  write strobe; write takes effect on the edge where WSel=1.
- HSel  in  1  read/select qualifier.
- HRData  out  DATA_WIDTH  read data; combinational from registers.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output, idle high.

Behaviour:
Reset (rst=1 at an edge, including mid-frame):
- uart_tx=1.
- TX and RX FSMs go to IDLE; counters cleared.
- TX_DATA=0, RX_DATA=0, all status bits 0.
- Synchronizer flops set to 1.

Register map (word offset):
- 0 TX_DATA: W latches [7:0]; R returns {24'b0, TX_DATA}.
- 1 TX_CTRL: W with bit0=1 starts a frame if TX is idle; ignored if busy. R returns {31'b0, tx_busy}.
- 2 RX_DATA: R returns {24'b0, last received byte}. W ignored.
- 3 STATUS: R returns {28'b0, overrun, frame_err, tx_busy, rx_valid}. W with bit0=1 clears rx_valid, frame_err and overrun.
- 4–7: R returns 0; W ignored.

Read path:
- HRData = selected register when HSel=1; otherwise 0.
- Zero latency (combinational); reads have no side effects.

TX FSM (IDLE, START, DATA, STOP):
- The write to TX_CTRL at edge N loads the shift register from TX_DATA and sets tx_busy; uart_tx goes low after edge N+1.
- Each state lasts CLKS_PER_BIT cycles.
- DATA shifts 8 bits, LSB first.
- STOP drives 1; at STOP end, tx_busy clears and the FSM returns to IDLE.
- Total frame: 10·CLKS_PER_BIT cycles.
- A TX_DATA write while busy updates the register but does not alter the frame in flight.

RX FSM (IDLE, START, DATA, STOP):
- uart_rx passes through a 2-flop synchronizer.
- IDLE → START on a synchronized low.
- At CLKS_PER_BIT/2: if the line is still low, go to DATA; otherwise return to IDLE (glitch rejection).
- Sample each data bit every CLKS_PER_BIT thereafter, LSB first.
- Sample the stop bit the same way:
  - Stop bit =1: RX_DATA ← byte, rx_valid ← 1.
  - Stop bit =0: frame_err ← 1, RX_DATA unchanged.
- If rx_valid is already 1 when a new byte completes, overwrite RX_DATA and set overrun.
- Return to IDLE after the stop sample; the next start may be detected the following cycle.

Simultaneous events:
- Byte completion and a STATUS clear-write on the same edge: completion wins (rx_valid=1, its flags set).
- TX_CTRL start and TX_DATA write cannot collide (single address).

Decomposition:
- Package uart_mmio_pkg holds:
  - register offsets (TX_DATA_OFF=0, TX_CTRL_OFF=1, RX_DATA_OFF=2, STATUS_OFF=3);
  - STATUS bit indices;
  - the 2-bit FSM state encoding shared by TX and RX.
- One natural sub-module: uart_rx_core (synchronizer, RX FSM, bit counter). It outputs byte[7:0], a byte_done pulse and a frame_err pulse.
- TX FSM and the register file stay in the top module.

Test Plan:
All scenarios use CLK_FREQ=160 and BAUD_RATE=10, so CLKS_PER_BIT=16.
1. Reset:
   - Stimulus: assert rst for 2 cycles mid-TX-frame.
   - Required: uart_tx=1 on the next cycle; reading offsets 0–3 returns 0.
2. TX frame:
   - Stimulus: write 0xA5 to offset 0, then 1 to offset 1.
   - Required: uart_tx low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. STATUS bit1=1 throughout and 0 after cycle 160.
3. Start while busy:
   - Stimulus: second TX_CTRL write mid-frame, with TX_DATA rewritten to 0x3C.
   - Required: the current frame still sends 0xA5; no second frame starts.
4. RX byte:
   - Stimulus: drive a 0x5A frame on uart_rx.
   - Required: STATUS=0x1 and RX_DATA=0x5A. Writing 1 to offset 3 returns STATUS to 0x0.
5. RX errors:
   - Stimulus: send 0x11 with stop=0.
   - Required: frame_err=1, RX_DATA keeps its previous value.
   - Stimulus: send two valid bytes 0x01 then 0x02 without a clear.
   - Required: RX_DATA=0x02 and STATUS bit3=1.
6. Select/decode:
   - Stimulus: HSel=0 with any address; read offsets 5 and 7; write to offset 6.
   - Required: HRData=0 when HSel=0; offsets 5 and 7 read 0; the write to offset 6 leaves all registers unchanged.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the state encoding used by both the TX and RX state machines.
package uart_mmio_pkg;

    localparam logic [2:0] TX_DATA_OFF = 3'd0;
    localparam logic [2:0] TX_CTRL_OFF = 3'd1;
    localparam logic [2:0] RX_DATA_OFF = 3'd2;
    localparam logic [2:0] STATUS_OFF  = 3'd3;

    localparam int ST_RX_VALID  = 0;
    localparam int ST_TX_BUSY   = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM with start-glitch rejection.
// Emits a one-cycle byte_done or frame_err pulse right after the stop-bit sample.
module uart_rx_core
    import uart_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       frame_err_o
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done_o = 1'b0;
        frame_err_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = S_START;
            end
            S_START: begin
                // Half a bit in: a line that has gone high again was only a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                    byte_done_o = sync2_q;
                    frame_err_o = !sync2_q;
                end
            end
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/uart_mmio_slave.sv
// Memory-mapped 8N1 UART: register file, TX FSM and read mux, with RX in uart_rx_core.
// Reads are combinational and side-effect free; writes act on the edge where WSel=1.
module uart_mmio_slave
    import uart_mmio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] map_Address,
    input  logic [DATA_WIDTH-1:0] map_Data,
    input  logic                  WSel,
    input  logic                  HSel,
    output logic [DATA_WIDTH-1:0] HRData,
    input  logic                  uart_rx,
    output logic                  uart_tx
);

    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST         = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0] off;
    logic       wr_tx_data, wr_tx_ctrl, wr_status;
    logic       unused_bits;

    assign off         = map_Address[2:0];
    assign wr_tx_data  = WSel && (off == TX_DATA_OFF);
    assign wr_tx_ctrl  = WSel && (off == TX_CTRL_OFF);
    assign wr_status   = WSel && (off == STATUS_OFF);
    assign unused_bits = ^{map_Address[ADDR_WIDTH-1:3], map_Data[DATA_WIDTH-1:8]};

    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             tx_busy;

    logic [7:0] rx_byte;
    logic       rx_done, rx_ferr;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (uart_rx),
        .byte_o      (rx_byte),
        .byte_done_o (rx_done),
        .frame_err_o (rx_ferr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_line_q   <= 1'b1;
            tx_data_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
            tx_data_q   <= tx_data_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (wr_tx_ctrl && map_Data[0]) begin
                    tx_state_d = S_START;
                    tx_shift_d = tx_data_q;
                    tx_bit_d   = '0;
                end
            end
            S_START: begin
                tx_line_d = 1'b0;
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end
            end
        endcase
    end

    assign tx_busy = (tx_state_q != S_IDLE);
    assign uart_tx = tx_line_q;

    // A completing byte or frame error overrides a same-edge STATUS clear.
    always_comb begin
        tx_data_d   = wr_tx_data ? map_Data[7:0] : tx_data_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (wr_status && map_Data[0]) begin
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (rx_done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q) overrun_d = 1'b1;
        end
        if (rx_ferr) frame_err_d = 1'b1;
    end

    logic [7:0] rd_val;

    always_comb begin
        rd_val = 8'h00;
        if (HSel) begin
            case (off)
                TX_DATA_OFF: rd_val = tx_data_q;
                TX_CTRL_OFF: rd_val = {7'b0, tx_busy};
                RX_DATA_OFF: rd_val = rx_data_q;
                STATUS_OFF: begin
                    rd_val[ST_OVERRUN]   = overrun_q;
                    rd_val[ST_FRAME_ERR] = frame_err_q;
                    rd_val[ST_TX_BUSY]   = tx_busy;
                    rd_val[ST_RX_VALID]  = rx_valid_q;
                end
                default: rd_val = 8'h00;
            endcase
        end
    end

    assign HRData = DATA_WIDTH'(rd_val);

endmodule

// File: tb/tb_uart_mmio_slave.sv
// Bench for uart_mmio_slave at 16 clocks per bit: random TX/RX bytes against a
// register-level model and an ideal 8N1 waveform computed from the byte value.
module tb_uart_mmio_slave;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] map_Address;
    logic [31:0] map_Data;
    logic        WSel;
    logic        HSel;
    logic [31:0] HRData;
    logic        uart_rx;
    logic        uart_tx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_tx_data, m_rx_data;
    bit         m_valid, m_ferr, m_ovr;

    always #5 clk = ~clk;

    uart_mmio_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .CLK_FREQ   (160),
        .BAUD_RATE  (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .map_Address (map_Address),
        .map_Data    (map_Data),
        .WSel        (WSel),
        .HSel        (HSel),
        .HRData      (HRData),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status(input bit busy);
        return {28'b0, m_ovr, m_ferr, busy, m_valid};
    endfunction

    task automatic model_reset();
        m_tx_data = 8'h00;
        m_rx_data = 8'h00;
        m_valid   = 1'b0;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
    endtask

    task automatic bus_write(input int off, input logic [31:0] d);
        @(negedge clk);
        map_Address = 32'(off);
        map_Data    = d;
        WSel        = 1'b1;
        HSel        = 1'b0;
        @(negedge clk);
        WSel = 1'b0;
        if (off == 0) m_tx_data = d[7:0];
        if (off == 3 && d[0]) begin
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic bus_read(input int off, output logic [31:0] d);
        @(negedge clk);
        map_Address = 32'(off);
        HSel        = 1'b1;
        #1;
        d    = HRData;
        HSel = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        bus_read(0, d); chk({tag, ".tx_data"}, d, {24'b0, m_tx_data});
        bus_read(1, d); chk({tag, ".tx_ctrl"}, d, 32'h0);
        bus_read(2, d); chk({tag, ".rx_data"}, d, {24'b0, m_rx_data});
        bus_read(3, d); chk({tag, ".status"},  d, m_status(1'b0));
    endtask

    // Line level k cycles after the starting edge: 16 low, 8 data bits LSB first, then high.
    function automatic logic ideal_line(input logic [7:0] b, input int k);
        int j;
        if (k < 1) return 1'b1;
        j = (k - 1) / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic tx_frame(input logic [7:0] b, input bit busy_write);
        bus_write(0, {24'b0, b});
        bus_write(1, 32'h1);
        for (int k = 1; k <= 10 * CPB + 40; k++) begin
            @(negedge clk);
            if (busy_write && k == 40) begin
                map_Address = 32'd0; map_Data = 32'h3C; WSel = 1'b1;
                m_tx_data = 8'h3C;
            end else if (busy_write && k == 41) begin
                map_Address = 32'd1; map_Data = 32'h1; WSel = 1'b1;
            end else begin
                WSel = 1'b0;
                map_Address = 32'd3;
                HSel = 1'b1;
                #1;
                chk("tx_busy", 32'(HRData[1]), 32'(k < 10 * CPB));
                HSel = 1'b0;
            end
            chk("tx_line", 32'(uart_tx), 32'(ideal_line(b, k)));
        end
        WSel = 1'b0;
        check_regs("after_tx");
    endtask

    task automatic rx_level(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx_level(1'b0, CPB);
        for (int i = 0; i < 8; i++) rx_level(b[i], CPB);
        if (stop_ok) rx_level(1'b1, CPB);
        else         rx_level(1'b0, 12);
        rx_level(1'b1, 24);
        if (stop_ok) begin
            if (m_valid) m_ovr = 1'b1;
            m_rx_data = b;
            m_valid   = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rb;

        rst = 1'b1; WSel = 1'b0; HSel = 1'b0; uart_rx = 1'b1;
        map_Address = '0; map_Data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("init.uart_tx", 32'(uart_tx), 32'h1);
        check_regs("init");

        // Reset in the middle of a frame.
        bus_write(0, 32'hC3);
        bus_write(1, 32'h1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.uart_tx", 32'(uart_tx), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst.idle_line", 32'(uart_tx), 32'h1);
        end
        check_regs("rst");

        // TX: directed 0xA5 with a rewrite and restart attempt mid-frame, then random bytes.
        tx_frame(8'hA5, 1'b1);
        chk("busy_rewrite.tx_data", {24'b0, m_tx_data}, 32'h3C);
        for (int i = 0; i < 2; i++) tx_frame(8'($urandom_range(0, 255)), 1'b0);

        // RX: directed 0x5A, clear, then random bytes each followed by a clear.
        rx_send(8'h5A, 1'b1);
        bus_read(3, d); chk("rx5a.status", d, 32'h1);
        bus_read(2, d); chk("rx5a.data", d, 32'h5A);
        bus_write(3, 32'h1);
        bus_read(3, d); chk("rx5a.cleared", d, 32'h0);
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            rx_send(rb, 1'b1);
            check_regs("rx_rand");
            bus_write(3, 32'h1);
            check_regs("rx_rand_clr");
        end

        // Short low pulse on the line must not produce a byte.
        @(negedge clk);
        rx_level(1'b0, 4);
        rx_level(1'b1, 12 * CPB);
        check_regs("glitch");

        // Framing error keeps RX_DATA, then overrun on two unread bytes.
        rx_send(8'h11, 1'b0);
        bus_read(3, d); chk("ferr.status", d, 32'h4);
        check_regs("ferr");
        bus_write(3, 32'h1);
        rx_send(8'h01, 1'b1);
        rx_send(8'h02, 1'b1);
        bus_read(2, d); chk("ovr.data", d, 32'h02);
        bus_read(3, d); chk("ovr.status", d, 32'h9);
        check_regs("ovr");
        bus_write(3, 32'h1);

        // Select and decode.
        bus_write(0, 32'h77);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            map_Address = $urandom;
            HSel = 1'b0;
            #1;
            chk("nosel", HRData, 32'h0);
        end
        bus_read(5, d); chk("off5", d, 32'h0);
        bus_read(7, d); chk("off7", d, 32'h0);
        bus_write(6, $urandom | 32'h1);
        check_regs("off6_write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
